// File: rtl/lcd_reader.sv
// -----------------------------------------------------------------------------
// lcd_reader
//
// Read-side companion to the character LCD write path. Runs HD44780-style
// read cycles on the LCD bus: a busy-flag/address-counter read (RS=0, RW=1)
// or a DDRAM/CGRAM data read (RS=1, RW=1). In poll mode the busy-flag read
// is repeated until BF clears or POLL_MAX reads have been made.
//
// The LCD top level arbitrates the pins: while bus_own is high it must route
// this block's lcd_rs/lcd_rw/lcd_e to the panel and release its own lcd_data
// driver so the panel can drive lcd_data_in.
//
// Ports:
//   clk          in   50 MHz system clock
//   reset        in   asynchronous, active-low reset
//   req          in   transaction request, accepted when req & ready
//   req_rs       in   0 = busy-flag/address read, 1 = data read
//   req_poll     in   1 = poll BF until clear (ignored for data reads)
//   ready        out  idle, a request can be accepted
//   rsp_valid    out  one-cycle pulse, response fields are valid
//   rsp_data     out  byte sampled from lcd_data_in
//   rsp_busy     out  rsp_data[7] for busy-flag reads, else 0
//   rsp_addr     out  rsp_data[6:0] for busy-flag reads, else 0
//   timeout      out  poll ended with BF still set
//   bus_own      out  this block owns the LCD pins
//   lcd_data_in  in   LCD data bus, read side
//   lcd_rs       out  register select
//   lcd_rw       out  read/write select (1 = read)
//   lcd_e        out  enable strobe
// -----------------------------------------------------------------------------
module lcd_reader #(
    parameter int T_AS     = 2,
    parameter int T_EH     = 25,
    parameter int T_EL     = 25,
    parameter int POLL_MAX = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_busy,
    output logic [6:0] rsp_addr,
    output logic       timeout,
    output logic       bus_own,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    // The phase counter only ever holds (longest phase - 1).
    localparam int T_MAX_AE = (T_AS > T_EH) ? T_AS : T_EH;
    localparam int T_MAX    = (T_MAX_AE > T_EL) ? T_MAX_AE : T_EL;
    localparam int PH_W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int POLL_W   = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    localparam logic [PH_W-1:0]   AS_LAST   = PH_W'(T_AS - 1);
    localparam logic [PH_W-1:0]   EH_LAST   = PH_W'(T_EH - 1);
    localparam logic [PH_W-1:0]   EL_LAST   = PH_W'(T_EL - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_E_LOW,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PH_W-1:0]     r_phaseCnt;
    logic [POLL_W-1:0]   r_pollCnt;
    logic                r_rs;
    logic                r_poll;
    logic [7:0]          r_capture;
    logic                w_phaseLast;
    logic                w_pollAgain;

    // Last cycle of the current timed phase.
    always_comb begin
        w_phaseLast = 1'b0;
        case (r_state)
            S_SETUP:  w_phaseLast = (r_phaseCnt == AS_LAST);
            S_E_HIGH: w_phaseLast = (r_phaseCnt == EH_LAST);
            S_E_LOW:  w_phaseLast = (r_phaseCnt == EL_LAST);
            default:  w_phaseLast = 1'b0;
        endcase
    end

    // Another busy-flag read is due only while BF is still set and the
    // read budget is not used up; the compare also keeps the counter from
    // ever wrapping.
    assign w_pollAgain = r_poll & r_capture[7] & (r_pollCnt < POLL_LAST);

    // Next state and pin/handshake outputs, decoded straight from the state
    // so that reset drops lcd_e at once.
    always_comb begin
        w_nextState = r_state;
        ready       = 1'b0;
        rsp_valid   = 1'b0;
        bus_own     = 1'b0;
        lcd_rs      = 1'b0;
        lcd_rw      = 1'b0;
        lcd_e       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    w_nextState = S_SETUP;
                end
            end
            S_SETUP: begin
                bus_own = 1'b1;
                lcd_rs  = r_rs;
                lcd_rw  = 1'b1;
                if (w_phaseLast) begin
                    w_nextState = S_E_HIGH;
                end
            end
            S_E_HIGH: begin
                bus_own = 1'b1;
                lcd_rs  = r_rs;
                lcd_rw  = 1'b1;
                lcd_e   = 1'b1;
                if (w_phaseLast) begin
                    w_nextState = S_E_LOW;
                end
            end
            S_E_LOW: begin
                bus_own = 1'b1;
                lcd_rs  = r_rs;
                lcd_rw  = 1'b1;
                if (w_phaseLast) begin
                    w_nextState = w_pollAgain ? S_SETUP : S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid   = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Phase timer restarts at every phase boundary and sits at zero outside
    // the timed phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phaseCnt <= '0;
        end else if (w_phaseLast || r_state == S_IDLE || r_state == S_DONE) begin
            r_phaseCnt <= '0;
        end else begin
            r_phaseCnt <= r_phaseCnt + PH_W'(1);
        end
    end

    // Request capture, data sampling, poll iteration and response update.
    // Data is taken on the edge that ends the E-high phase, while the panel
    // is still driving the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs      <= 1'b0;
            r_poll    <= 1'b0;
            r_pollCnt <= '0;
            r_capture <= 8'h00;
            rsp_data  <= 8'h00;
            rsp_busy  <= 1'b0;
            rsp_addr  <= 7'h00;
            timeout   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_rs      <= req_rs;
                r_poll    <= req_poll & ~req_rs;
                r_pollCnt <= '0;
            end
            if (r_state == S_E_HIGH && w_phaseLast) begin
                r_capture <= lcd_data_in;
            end
            if (r_state == S_E_LOW && w_phaseLast) begin
                if (w_pollAgain) begin
                    r_pollCnt <= r_pollCnt + POLL_W'(1);
                end else begin
                    rsp_data <= r_capture;
                    rsp_busy <= ~r_rs & r_capture[7];
                    rsp_addr <= r_rs ? 7'h00 : r_capture[6:0];
                    timeout  <= r_poll & r_capture[7];
                end
            end
        end
    end

endmodule
